// File: rtl/div_sequencer.sv
`timescale 1ns/1ps
// div_sequencer: multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU).
// Radix-2 restoring divider on operand magnitudes, one iteration per cycle,
// with sign fix-up and divide-by-zero / signed-overflow results applied on
// the edge entering DONE.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip
// the iterations and go IDLE->DONE directly.
module div_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Only op[1] (quotient vs remainder) matters after acceptance; the
    // signed/unsigned choice is folded into the latched signs and magnitudes.
    logic        r_is_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic        r_ovf;
    logic [31:0] r_dividend;
    logic [31:0] r_dvs_mag;
    logic [31:0] r_quo;
    logic [32:0] r_rem;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_signed;
    logic        w_dvd_neg;
    logic        w_dvs_neg;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic        w_in_div0;
    logic        w_in_ovf;
    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic        w_ge;
    logic [32:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_calc_result;
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] w_spec_result;
`endif

    // Request decode, operand conditioning and one restoring iteration.
    always_comb begin
        w_accept   = (r_state == IDLE) & start & ~flush;
        w_signed   = ~op[0];
        w_dvd_neg  = w_signed & dividend[31];
        w_dvs_neg  = w_signed & divisor[31];
        w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
        w_dvs_mag  = w_dvs_neg ? -divisor  : divisor;
        w_in_div0  = (divisor == '0);
        w_in_ovf   = w_signed & (dividend == 32'h8000_0000) & (divisor == '1);

        w_shift    = {r_rem, r_quo[31]};
        w_diff     = w_shift - {2'b00, r_dvs_mag};
        w_ge       = ~w_diff[33];
        w_rem_next = w_ge ? w_diff[32:0] : w_shift[32:0];
        w_quo_next = {r_quo[30:0], w_ge};

        w_quo_fix  = r_neg_q ? -w_quo_next : w_quo_next;
        w_rem_fix  = r_neg_r ? -w_rem_next[31:0] : w_rem_next[31:0];

        if (r_div0)
            w_calc_result = r_is_rem ? r_dividend : '1;
        else if (r_ovf)
            w_calc_result = r_is_rem ? '0 : 32'h8000_0000;
        else
            w_calc_result = r_is_rem ? w_rem_fix : w_quo_fix;
`ifdef DIV_EARLY_OUT_EN
        if (w_in_div0)
            w_spec_result = op[1] ? dividend : '1;
        else
            w_spec_result = op[1] ? '0 : 32'h8000_0000;
`endif
    end

    // State register; reset dominates flush and start.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic; flush returns to IDLE from any state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef DIV_EARLY_OUT_EN
                    w_state_next = (w_in_div0 | w_in_ovf) ? DONE : CALC;
`else
                    w_state_next = CALC;
`endif
                end
            end
            CALC:    if (r_cnt == 5'd31) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (flush)
            w_state_next = IDLE;
    end

    // Outputs decoded from state; stall is also raised in the acceptance cycle.
    always_comb begin
        busy   = (r_state != IDLE);
        stall  = (w_accept & ~rst) | (r_state == CALC);
        done   = (r_state == DONE);
        result = r_result;
    end

    // Datapath: latch operands on acceptance, iterate in CALC, and load
    // result only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_rem   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
            r_dividend <= '0;
            r_dvs_mag  <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
        end else if (w_accept) begin
            r_is_rem   <= op[1];
            r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r    <= w_dvd_neg;
            r_div0     <= w_in_div0;
            r_ovf      <= w_in_ovf;
            r_dividend <= dividend;
            r_dvs_mag  <= w_dvs_mag;
            r_quo      <= w_dvd_mag;
            r_rem      <= '0;
            r_cnt      <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (w_in_div0 | w_in_ovf)
                r_result <= w_spec_result;
`endif
        end else if ((r_state == CALC) && !flush) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31)
                r_result <= w_calc_result;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for div_sequencer: spec vector table, randomized
// operations against an arithmetic reference model, and hand-written
// flush / reset / held-start sequences.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_last = '0;

    div_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Cycles from acceptance to the done pulse.
    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        return 33;
    endfunction

    // Called just after a negedge; returns just after a negedge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int lat;
        int n;
        bit seen;
        lat = ref_lat(o, a, b);
        op = o; dividend = a; divisor = b; start = 1'b1;
        #1;
        chk({tag, " stall@accept"}, {31'd0, stall}, 32'd1);
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            start = 1'b0;
            dividend = $urandom;
            divisor = $urandom;
            op = 2'($urandom);
            n++;
            if (done) seen = 1;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " result"}, result, exp);
        chk({tag, " stall@done"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk({tag, " done_pulse_end"}, {31'd0, done}, 32'd0);
        chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
        exp_last = exp;
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[5]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[6]  = '{2'b10, 32'd5,          32'd0,          32'd5};
        vecs[7]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[8]  = '{2'b11, 32'd5,          32'd0,          32'd5};
        vecs[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[11] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[12] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset busy",   {31'd0, busy},  32'd0);
        chk("reset stall",  {31'd0, stall}, 32'd0);
        chk("reset done",   {31'd0, done},  32'd0);
        chk("reset result", result,         32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Spec vectors
        for (int i = 0; i < 13; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom);
            ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = 32'($urandom);
            endcase
            run_op(ro, ra, rb, ref_div(ro, ra, rb), $sformatf("rnd%0d", i));
        end

        // Flush at iteration 10: abort, then a new DIVU 9/3 the following cycle
        begin
            int  n;
            bit  saw_done;
            op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
            saw_done = 0;
            for (n = 1; n <= 11; n++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) saw_done = 1;
            end
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            if (done) saw_done = 1;
            chk("flush busy",    {31'd0, busy},     32'd0);
            chk("flush no_done", {31'd0, saw_done}, 32'd0);
            chk("flush result",  result,            exp_last);
            run_op(2'b01, 32'd9, 32'd3, 32'd3, "after_flush");
        end

        // Start held high throughout CALC: one pulse per acceptance
        begin
            int n;
            int pulses;
            int first;
            op = 2'b00; dividend = 32'hFFFF_FF9C; divisor = 32'd7; start = 1'b1;
            n = 0; pulses = 0; first = 0;
            while (pulses == 0 && n < 40) begin
                @(negedge clk);
                n++;
                if (done) begin
                    pulses++;
                    first = n;
                    chk("held result", result, 32'hFFFF_FFF2);
                    start = 1'b0;
                end
            end
            repeat (3) begin
                @(negedge clk);
                if (done) pulses++;
            end
            chk("held latency", 32'(first), 32'd33);
            chk("held pulses",  32'(pulses), 32'd1);
            chk("held busy",    {31'd0, busy}, 32'd0);
        end

        // Flush and start together in IDLE: flush wins
        flush = 1'b1; start = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd5;
        #1;
        chk("flush_start stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush_start busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("flush_start done", {31'd0, done}, 32'd0);

        // Reset mid-CALC
        op = 2'b01; dividend = 32'd12345; divisor = 32'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midcalc busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst busy",   {31'd0, busy},  32'd0);
        chk("rst stall",  {31'd0, stall}, 32'd0);
        chk("rst done",   {31'd0, done},  32'd0);
        chk("rst result", result,         32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b11, 32'd12345, 32'd11, 32'd3, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
